// File: rtl/regfile_rsp_pkg.sv
// Shared constants, state encoding and the read-selection helper for the
// decode-stage register-read responder.
//
// Contents:
//   DW / AW / NREG      data width, address width, register count
//   rf_state_e          scrub sequencer states (RF_CLEAR, RF_READY)
//   read_rule()         value returned by a read port for a given request
package regfile_rsp_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam logic          RST_ENABLE   = 1'b1;
  localparam logic          WRITE_ENABLE = 1'b1;
  localparam logic          READ_ENABLE  = 1'b1;
  localparam logic [DW-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [AW-1:0] NOP_REG_ADDR = 5'd0;
  localparam logic [AW-1:0] FIRST_SCRUB  = 5'd1;
  localparam logic [AW-1:0] LAST_REG     = 5'd31;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Read value for one port, highest priority first: reset/disabled/r0 give
  // zero, the file gives zero while it is still being scrubbed, a same-cycle
  // write to the same register is forwarded, otherwise the stored word.
  function automatic logic [DW-1:0] read_rule(
    input logic          rst_s,
    input logic          en_s,
    input logic [AW-1:0] addr_s,
    input logic          ready_s,
    input logic          we_s,
    input logic [AW-1:0] waddr_s,
    input logic [DW-1:0] wdata_s,
    input logic [DW-1:0] word_s
  );
    logic [DW-1:0] val_s;
    if (rst_s == RST_ENABLE || en_s != READ_ENABLE || addr_s == NOP_REG_ADDR) begin
      val_s = ZERO_WORD;
    end else if (!ready_s) begin
      val_s = ZERO_WORD;
    end else if (we_s == WRITE_ENABLE && waddr_s == addr_s) begin
      val_s = wdata_s;
    end else begin
      val_s = word_s;
    end
    return val_s;
  endfunction

endpackage

// File: rtl/regfile_rsp_if.sv
// Decode / write-back / debug bundle of the register file responder.
//
// Modports:
//   master  decode + write-back + debug requester (drives requests)
//   slave   register file (drives read data, status and debug response)
interface regfile_rsp_if;
  import regfile_rsp_pkg::*;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          ready_o;
  logic          err_o;
  logic          dbg_re;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          dbg_valid;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_re, dbg_addr,
    input  rdata1, rdata2, ready_o, err_o, dbg_data, dbg_valid
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_re, dbg_addr,
    output rdata1, rdata2, ready_o, err_o, dbg_data, dbg_valid
  );

endinterface

// File: rtl/regfile_rsp_scrub_fsm.sv
// Post-reset scrub sequencer: walks r1..r31 writing zero, one register per
// clock, then reports the file usable.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset; restarts the scrub at r1
//   ready_o     1 once r31 has been written
//   scrub_we    array write request from the sequencer (1 while clearing)
//   scrub_addr  register being cleared this cycle
module regfile_scrub_fsm
  import regfile_rsp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic          ready_o,
  output logic          scrub_we,
  output logic [AW-1:0] scrub_addr
);

  rf_state_e     state_r;
  rf_state_e     state_nxt_s;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_nxt_s;

  // State and scrub pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RF_CLEAR;
      ptr_r   <= FIRST_SCRUB;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Next-state: advance through the file; the edge clearing r31 ends the
  // scrub and the pointer is held there so it never wraps.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      RF_CLEAR: begin
        if (ptr_r == LAST_REG) begin
          state_nxt_s = RF_READY;
          ptr_nxt_s   = ptr_r;
        end else begin
          state_nxt_s = RF_CLEAR;
          ptr_nxt_s   = ptr_r + 5'd1;
        end
      end
      RF_READY: begin
        state_nxt_s = RF_READY;
        ptr_nxt_s   = ptr_r;
      end
      default: begin
        state_nxt_s = RF_CLEAR;
        ptr_nxt_s   = FIRST_SCRUB;
      end
    endcase
  end

  assign ready_o    = (state_r == RF_READY);
  assign scrub_we   = (state_r == RF_CLEAR);
  assign scrub_addr = ptr_r;

endmodule

// File: rtl/regfile_rsp.sv
// Register-read responder: 32x32 GPR file with two combinational read ports
// (write-through bypass), one write-back port, a post-reset scrub, a sticky
// error for writes during the scrub and a registered debug read port.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous active-high reset (array contents are not reset)
//   bus   regfile_rsp_if.slave: we/waddr/wdata, re1/raddr1/rdata1,
//         re2/raddr2/rdata2, ready_o, err_o, dbg_re/dbg_addr/dbg_data/dbg_valid
module regfile_rsp
  import regfile_rsp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  regfile_rsp_if.slave  bus
);

  logic [DW-1:0] mem_r [NREG];
  logic          ready_s;
  logic          scrub_we_s;
  logic [AW-1:0] scrub_addr_s;
  logic          err_r;
  logic [DW-1:0] dbg_data_r;
  logic          dbg_valid_r;
  logic [DW-1:0] rdata1_s;
  logic [DW-1:0] rdata2_s;
  logic [DW-1:0] dbg_rd_s;

  regfile_scrub_fsm u_scrub (
    .clk        (clk),
    .rst        (rst),
    .ready_o    (ready_s),
    .scrub_we   (scrub_we_s),
    .scrub_addr (scrub_addr_s)
  );

  // Array write mux: scrub owns the array while clearing, so external writes
  // in that window are simply dropped. r0 is never stored.
  always_ff @(posedge clk) begin
    if (scrub_we_s) begin
      mem_r[scrub_addr_s] <= ZERO_WORD;
    end else if (bus.we == WRITE_ENABLE && bus.waddr != NOP_REG_ADDR) begin
      mem_r[bus.waddr] <= bus.wdata;
    end
  end

  // Sticky error: any write request seen before the file is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (bus.we == WRITE_ENABLE && !ready_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Read selection for both decode ports and the debug port.
  always_comb begin
    rdata1_s = read_rule(rst, bus.re1, bus.raddr1, ready_s, bus.we,
                         bus.waddr, bus.wdata, mem_r[bus.raddr1]);
    rdata2_s = read_rule(rst, bus.re2, bus.raddr2, ready_s, bus.we,
                         bus.waddr, bus.wdata, mem_r[bus.raddr2]);
    dbg_rd_s = read_rule(rst, READ_ENABLE, bus.dbg_addr, ready_s, bus.we,
                         bus.waddr, bus.wdata, mem_r[bus.dbg_addr]);
  end

  // Debug response register: capture on request, valid for one cycle,
  // data holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data_r  <= ZERO_WORD;
      dbg_valid_r <= 1'b0;
    end else if (bus.dbg_re) begin
      dbg_data_r  <= dbg_rd_s;
      dbg_valid_r <= 1'b1;
    end else begin
      dbg_data_r  <= dbg_data_r;
      dbg_valid_r <= 1'b0;
    end
  end

  assign bus.rdata1    = rdata1_s;
  assign bus.rdata2    = rdata2_s;
  assign bus.ready_o   = ready_s;
  assign bus.err_o     = err_r;
  assign bus.dbg_data  = dbg_data_r;
  assign bus.dbg_valid = dbg_valid_r;

endmodule

// File: tb/tb_regfile_rsp.sv
// Self-checking bench for regfile_rsp: directed scenarios plus randomized
// traffic compared against a behavioural model of the register file.
module tb_regfile_rsp;
  import regfile_rsp_pkg::*;

  logic clk;
  logic rst;

  regfile_rsp_if bus ();

  regfile_rsp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_edges;
  bit          m_err;
  logic [31:0] m_dbg_data;
  bit          m_dbg_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input bit en, input logic [4:0] addr);
    if (!en || addr == 5'd0) return 32'h0;
    if (!m_ready) return 32'h0;
    if (bus.we && bus.waddr == addr) return bus.wdata;
    return m_mem[addr];
  endfunction

  task automatic idle_inputs();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    bus.re1 = 1'b0; bus.raddr1 = 5'd0;
    bus.re2 = 1'b0; bus.raddr2 = 5'd0;
    bus.dbg_re = 1'b0; bus.dbg_addr = 5'd0;
  endtask

  // Called at +1 after a rising edge: move to mid-cycle and check read ports.
  task automatic pre_edge();
    #4;
    check_eq("rdata1", bus.rdata1, model_read(bus.re1, bus.raddr1));
    check_eq("rdata2", bus.rdata2, model_read(bus.re2, bus.raddr2));
  endtask

  // Apply the edge to the model, take the edge, check registered outputs.
  task automatic post_edge();
    if (bus.dbg_re) begin
      m_dbg_data  = model_read(1'b1, bus.dbg_addr);
      m_dbg_valid = 1'b1;
    end else begin
      m_dbg_valid = 1'b0;
    end
    if (!m_ready) begin
      if (bus.we) m_err = 1'b1;
      m_edges++;
      if (m_edges == 31) m_ready = 1'b1;
    end else if (bus.we && bus.waddr != 5'd0) begin
      m_mem[bus.waddr] = bus.wdata;
    end
    @(posedge clk);
    #1;
    check_eq("ready_o", bus.ready_o, m_ready);
    check_eq("err_o", bus.err_o, m_err);
    check_eq("dbg_valid", bus.dbg_valid, m_dbg_valid);
    check_eq("dbg_data", bus.dbg_data, m_dbg_data);
  endtask

  task automatic step();
    pre_edge();
    post_edge();
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release after one edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m_ready = 1'b0; m_edges = 0; m_err = 1'b0;
    m_dbg_data = 32'h0; m_dbg_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    check_eq("rst_ready", bus.ready_o, 32'h0);
    check_eq("rst_err", bus.err_o, 32'h0);
    check_eq("rst_rdata1", bus.rdata1, 32'h0);
    check_eq("rst_rdata2", bus.rdata2, 32'h0);
    check_eq("rst_dbg_valid", bus.dbg_valid, 32'h0);
    check_eq("rst_dbg_data", bus.dbg_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    apply_reset();

    // Scrub: ready_o low for 30 edges, high from edge 31 (checked in post_edge)
    for (int i = 0; i < 31; i++) step();
    check_eq("t1_ready", bus.ready_o, 32'h1);
    // Debug read of every scrubbed register
    for (int i = 1; i < 32; i++) begin
      bus.dbg_re = 1'b1; bus.dbg_addr = i[4:0];
      step();
      check_eq("t1_dbg_zero", bus.dbg_data, 32'h0);
    end
    idle_inputs();

    // Write r5, then read it while bypassing a write to r7 on port 2
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    step();
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    pre_edge();
    check_eq("t2_rd1", bus.rdata1, 32'hDEADBEEF);
    check_eq("t2_bypass", bus.rdata2, 32'h12345678);
    post_edge();
    idle_inputs();

    // Disabled port reads zero; debug read returns r5 then drops valid
    bus.re1 = 1'b0; bus.raddr1 = 5'd5;
    bus.dbg_re = 1'b1; bus.dbg_addr = 5'd5;
    pre_edge();
    check_eq("t6_re_off", bus.rdata1, 32'h0);
    post_edge();
    check_eq("t6_dbg_valid", bus.dbg_valid, 32'h1);
    check_eq("t6_dbg_data", bus.dbg_data, 32'hDEADBEEF);
    bus.dbg_re = 1'b0;
    step();
    check_eq("t6_dbg_drop", bus.dbg_valid, 32'h0);
    check_eq("t6_dbg_hold", bus.dbg_data, 32'hDEADBEEF);

    // r0 is hardwired zero, including against a same-cycle write
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    pre_edge();
    check_eq("t3_r0_same", bus.rdata1, 32'h0);
    post_edge();
    bus.we = 1'b0;
    pre_edge();
    check_eq("t3_r0_next", bus.rdata1, 32'h0);
    post_edge();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.we     = ($urandom_range(0, 1) == 1);
      bus.waddr  = 5'($urandom_range(0, 31));
      bus.wdata  = $urandom;
      bus.re1    = ($urandom_range(0, 3) != 0);
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.re2    = ($urandom_range(0, 3) != 0);
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
      bus.dbg_re = ($urandom_range(0, 1) == 1);
      bus.dbg_addr = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      step();
    end

    // Write during scrub: dropped, sticky error
    idle_inputs();
    apply_reset();
    step();
    step();
    bus.we = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'hA5A5A5A5;
    step();
    check_eq("t4_err", bus.err_o, 32'h1);
    idle_inputs();
    for (int i = 0; i < 28; i++) step();
    check_eq("t4_ready", bus.ready_o, 32'h1);
    check_eq("t4_err_sticky", bus.err_o, 32'h1);
    bus.re1 = 1'b1; bus.raddr1 = 5'd2;
    pre_edge();
    check_eq("t4_r2_zero", bus.rdata1, 32'h0);
    post_edge();

    // Async reset from READY wipes r9 through the re-scrub and clears err_o
    idle_inputs();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h1;
    step();
    idle_inputs();
    bus.re1 = 1'b1; bus.raddr1 = 5'd9;
    pre_edge();
    check_eq("t5_r9_set", bus.rdata1, 32'h1);
    post_edge();
    apply_reset();
    for (int i = 0; i < 31; i++) step();
    pre_edge();
    check_eq("t5_r9_zero", bus.rdata1, 32'h0);
    check_eq("t5_err_clr", bus.err_o, 32'h0);
    post_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
